seq_divider_8b: RTL and testbench

SEQ_DIVIDER_8B -- requirements
Module: seq_divider_8b

---
 rtl/seq_divider_8b.sv | 107 ++++++++++
 tb/tb_seq_divider_8b.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_8b.sv
// rtl/seq_divider_8b.sv - 8-bit by 4-bit sequential restoring divider, one quotient bit per clock
module seq_divider_8b (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nx;
  logic [7:0] dvd_sh;
  logic [3:0] dvs_r;
  logic [4:0] part_rem;
  logic [2:0] iter;
  logic [4:0] shifted;
  logic [4:0] trial;
  logic       q_bit;
  logic       accept;
  logic       last_iter;
  logic       unused_rem_msb;

  // dvd_sh shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    shifted   = {part_rem[3:0], dvd_sh[7]};
    q_bit     = (shifted >= {1'b0, dvs_r});
    trial     = q_bit ? (shifted - {1'b0, dvs_r}) : shifted;
    last_iter = (iter == 3'd7);
  end

  // A restoring step always leaves part_rem below the divisor, so bit 4 never feeds the next shift
  assign unused_rem_msb = part_rem[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = (divisor == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_sh      <= 8'h00;
      dvs_r       <= 4'h0;
      part_rem    <= 5'h00;
      iter        <= 3'd0;
      quotient    <= 8'h00;
      remainder   <= 4'h0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divisor == 4'd0) begin
        quotient    <= 8'hFF;
        remainder   <= dividend[3:0];
        div_by_zero <= 1'b1;
      end else begin
        dvd_sh   <= dividend;
        dvs_r    <= divisor;
        part_rem <= 5'h00;
        iter     <= 3'd0;
      end
    end else if (state == RUN) begin
      part_rem <= trial;
      dvd_sh   <= {dvd_sh[6:0], q_bit};
      iter     <= iter + 3'd1;
      // Visible results change only here, never mid-iteration
      if (last_iter) begin
        quotient    <= {dvd_sh[6:0], q_bit};
        remainder   <= trial[3:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_8b.sv
// tb/tb_seq_divider_8b.sv - scoreboard bench for seq_divider_8b with a plain-arithmetic reference model
module tb_seq_divider_8b;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic [7:0] held_q = 8'h00;
  logic [3:0] held_r = 4'h0;
  logic       held_dz = 1'b0;
  logic       sweep_on = 1'b0;
  int         sweep_dones = 0;
  int         last_done_cyc = 0;

  seq_divider_8b dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int issue_cyc);
    exp_t e;
    if (b == 0) begin
      e.q   = 8'hFF;
      e.r   = a[3:0];
      e.dz  = 1'b1;
      e.cyc = issue_cyc + 1;
    end else begin
      e.q   = 8'(a / b);
      e.r   = 4'(a % b);
      e.dz  = 1'b0;
      e.cyc = issue_cyc + 9;
    end
    return e;
  endfunction

  // Monitor: every falling edge, either a done is scored or the outputs must hold
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_q  = 8'h00;
      held_r  = 4'h0;
      held_dz = 1'b0;
      chk("done_in_reset", int'(done), 0);
    end else if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("quotient", int'(quotient), int'(e.q));
        chk("remainder", int'(remainder), int'(e.r));
        chk("div_by_zero", int'(div_by_zero), int'(e.dz));
        chk("done_cycle", cyc, e.cyc);
        chk("busy_in_done", int'(busy), 1);
        if (sweep_on) begin
          if (sweep_dones > 0) chk("done_spacing", cyc - last_done_cyc, 10);
          sweep_dones = sweep_dones + 1;
        end
        last_done_cyc = cyc;
        held_q  = e.q;
        held_r  = e.r;
        held_dz = e.dz;
      end
    end else begin
      chk("outputs_hold", int'({quotient, remainder, div_by_zero}), int'({held_q, held_r, held_dz}));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  // Drive a one-cycle start pulse from a falling edge in IDLE
  task automatic issue(input int a, input int b, input bit push);
    wait_idle();
    dividend = 8'(a);
    divisor  = 4'(b);
    start    = 1'b1;
    if (push) exp_q.push_back(model(a, b, cyc));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 4'h0;
    #3;
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_flags", int'({busy, done, div_by_zero}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 200/7 with busy counted across RUN and DONE
    issue(200, 7, 1);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, 9);
    drain();

    issue(255, 15, 1);
    issue(5, 9, 1);
    issue(8'hAB, 0, 1);
    issue(100, 3, 1);
    drain();

    // Second request during RUN must be dropped and operand changes ignored
    issue(100, 3, 1);
    @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 4'd5;
    @(negedge clk);
    start = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom);
    drain();
    repeat (12) @(negedge clk);

    // Asynchronous reset in the 4th RUN cycle aborts without a done
    issue(200, 7, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_flags", int'({busy, done, div_by_zero}), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(17, 4, 1);
    drain();

    // Random operands and gaps, divisor zero included
    for (int i = 0; i < 40; i++) begin
      issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // Exhaustive nonzero sweep with start held high throughout
    sweep_on = 1'b1;
    start = 1'b1;
    for (int b = 1; b < 16; b++) begin
      for (int a = 0; a < 256; a++) begin
        wait_idle();
        dividend = 8'(a);
        divisor  = 4'(b);
        exp_q.push_back(model(a, b, cyc));
        @(negedge clk);
      end
    end
    start = 1'b0;
    drain();
    sweep_on = 1'b0;
    chk("sweep_count", sweep_dones, 256 * 15);

    repeat (12) @(negedge clk);
    chk("leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

endmodule
